// File: rtl/word_check_arbiter_if.sv
// Handshake bundle between the two text requesters, the arbiter and the shared checker.
// master: arbiter side (drives ready, checker input/reset and responses).
// slave : requester/checker side (drives valid/char and the checker verdict).
interface word_check_arbiter_if;
   logic [1:0]  req_valid;
   logic [15:0] req_char;
   logic [1:0]  req_ready;
   logic [7:0]  chk_in;
   logic        chk_rst;
   logic        chk_result;
   logic [1:0]  resp_valid;
   logic        resp_result;
   logic        resp_abort;
   logic [15:0] resp_len;

   modport master (
      input  req_valid, req_char, chk_result,
      output req_ready, chk_in, chk_rst, resp_valid, resp_result, resp_abort, resp_len
   );

   modport slave (
      output req_valid, req_char, chk_result,
      input  req_ready, chk_in, chk_rst, resp_valid, resp_result, resp_abort, resp_len
   );
endinterface

// File: rtl/word_check_arbiter.sv
// Purpose : shares one begin/end word checker between two character requesters, one session at a time.
// Latency : char accepted at E is on chk_in after E; TERM acceptance to resp_valid pulse is 2 cycles.
// Backpressure: only the granted requester sees ready (= its valid); the other is held off until granted.
// Ports   : clk, reset (async, active-high), bus (word_check_arbiter_if.master): req_valid/req_char/req_ready,
//           chk_in/chk_rst/chk_result to the checker, resp_valid/resp_result/resp_abort/resp_len back.
// Optional: ARB_TIMEOUT_EN enables the STREAM idle timeout (parameter TIMEOUT) and the abort flag.
module word_check_arbiter
`ifdef ARB_TIMEOUT_EN
#(
   parameter int unsigned TIMEOUT = 255
)
`endif
(
   input  logic                        clk,
   input  logic                        reset,
   word_check_arbiter_if.master        bus
);

   localparam logic [7:0] TERM = 8'h0A;
   localparam logic [7:0] FILL = 8'h20;

   typedef enum logic [2:0] {
      S_IDLE,
      S_STREAM,
      S_FLUSH,
      S_SAMPLE,
      S_CLEAR
   } state_t;

   state_t      state_q, state_d;
   logic        gnt_q, gnt_d;
   logic        last_q, last_d;
   logic [15:0] len_q, len_d;
   logic [7:0]  chk_in_q, chk_in_d;
   logic        chk_rst_q, chk_rst_d;
   logic [1:0]  resp_valid_q, resp_valid_d;
   logic        resp_result_q, resp_result_d;
   logic [15:0] resp_len_q, resp_len_d;

`ifdef ARB_TIMEOUT_EN
   // Idle count value at which the next idle edge terminates the session.
   localparam logic [7:0] IDLE_LIMIT = 8'(TIMEOUT - 1);
   logic [7:0]  idle_q, idle_d;
   logic        abort_q, abort_d;
   logic        resp_abort_q, resp_abort_d;
`endif

   logic [1:0]  ready;
   logic        acc;
   logic [7:0]  gchar;

   assign gchar = gnt_q ? bus.req_char[15:8] : bus.req_char[7:0];

   // Ready simply mirrors the granted requester's valid while streaming.
   always_comb begin
      ready = 2'b00;
      if (state_q == S_STREAM) begin
         ready[gnt_q] = bus.req_valid[gnt_q];
      end
   end

   assign acc = ready[gnt_q];

   always_comb begin
      state_d       = state_q;
      gnt_d         = gnt_q;
      last_d        = last_q;
      len_d         = len_q;
      chk_in_d      = FILL;
      chk_rst_d     = 1'b0;
      resp_valid_d  = 2'b00;
      resp_result_d = resp_result_q;
      resp_len_d    = resp_len_q;
`ifdef ARB_TIMEOUT_EN
      idle_d        = idle_q;
      abort_d       = abort_q;
      resp_abort_d  = resp_abort_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (|bus.req_valid) begin
               // On a tie, serve whoever was not served last.
               gnt_d   = (&bus.req_valid) ? ~last_q : bus.req_valid[1];
               len_d   = 16'd0;
               state_d = S_STREAM;
`ifdef ARB_TIMEOUT_EN
               idle_d  = 8'd0;
               abort_d = 1'b0;
`endif
            end
         end
         S_STREAM: begin
            if (acc) begin
`ifdef ARB_TIMEOUT_EN
               idle_d = 8'd0;
`endif
               if (gchar == TERM) begin
                  state_d = S_FLUSH;
               end else begin
                  chk_in_d = gchar;
                  len_d    = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
               end
            end
`ifdef ARB_TIMEOUT_EN
            else if (idle_q == IDLE_LIMIT) begin
               abort_d = 1'b1;
               state_d = S_FLUSH;
            end else begin
               idle_d = idle_q + 8'd1;
            end
`endif
         end
         // The flush space lets the checker close the last word before sampling.
         S_FLUSH: begin
            state_d = S_SAMPLE;
         end
         S_SAMPLE: begin
            resp_result_d = bus.chk_result;
            resp_len_d    = len_q;
`ifdef ARB_TIMEOUT_EN
            resp_abort_d  = abort_q;
`endif
            resp_valid_d  = gnt_q ? 2'b10 : 2'b01;
            chk_rst_d     = 1'b1;
            last_d        = gnt_q;
            state_d       = S_CLEAR;
         end
         S_CLEAR: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         gnt_q         <= 1'b0;
         last_q        <= 1'b1;
         len_q         <= 16'd0;
         chk_in_q      <= FILL;
         chk_rst_q     <= 1'b0;
         resp_valid_q  <= 2'b00;
         resp_result_q <= 1'b0;
         resp_len_q    <= 16'd0;
`ifdef ARB_TIMEOUT_EN
         idle_q        <= 8'd0;
         abort_q       <= 1'b0;
         resp_abort_q  <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         gnt_q         <= gnt_d;
         last_q        <= last_d;
         len_q         <= len_d;
         chk_in_q      <= chk_in_d;
         chk_rst_q     <= chk_rst_d;
         resp_valid_q  <= resp_valid_d;
         resp_result_q <= resp_result_d;
         resp_len_q    <= resp_len_d;
`ifdef ARB_TIMEOUT_EN
         idle_q        <= idle_d;
         abort_q       <= abort_d;
         resp_abort_q  <= resp_abort_d;
`endif
      end
   end

   assign bus.req_ready   = ready;
   assign bus.chk_in      = chk_in_q;
   assign bus.chk_rst     = chk_rst_q;
   assign bus.resp_valid  = resp_valid_q;
   assign bus.resp_result = resp_result_q;
   assign bus.resp_len    = resp_len_q;
`ifdef ARB_TIMEOUT_EN
   assign bus.resp_abort  = resp_abort_q;
`else
   assign bus.resp_abort  = 1'b0;
`endif

endmodule

// File: tb/tb_word_check_arbiter.sv
// Bench for word_check_arbiter: two scripted requesters, a behavioural begin/end checker,
// and a response monitor; directed sessions with hand-computed verdicts and lengths.
module tb_word_check_arbiter;

   logic clk = 1'b0;
   logic reset;
   logic v0, v1;
   logic [7:0] c0, c1;
   int vectors = 0;
   int errs = 0;
   int cyc = 0;
   int term_cyc0 = 0;
   int last_cyc = 0;
   int rst_cnt = 0;
   int viol = 0;

   logic [1:0]  rv_q[$];
   logic        res_q[$];
   logic        ab_q[$];
   logic [15:0] len_log[$];

   word_check_arbiter_if bus();

   assign bus.req_valid = {v1, v0};
   assign bus.req_char  = {c1, c0};

`ifdef ARB_TIMEOUT_EN
   word_check_arbiter #(.TIMEOUT(4)) dut (.clk(clk), .reset(reset), .bus(bus));
`else
   word_check_arbiter dut (.clk(clk), .reset(reset), .bus(bus));
`endif

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural begin/end checker: words are split by spaces; balanced when no
   // unmatched "end" was seen and every "begin" has been closed.
   logic [39:0] wbuf;
   logic [3:0]  wlen;
   logic [7:0]  depth;
   logic        err;

   always @(posedge clk or posedge reset) begin
      if (reset || bus.chk_rst) begin
         wbuf <= '0; wlen <= '0; depth <= '0; err <= 1'b0;
      end else if (bus.chk_in == 8'h20) begin
         if (wlen == 4'd5 && wbuf == "begin") depth <= depth + 8'd1;
         else if (wlen == 4'd3 && wbuf[23:0] == "end") begin
            if (depth == 8'd0) err <= 1'b1;
            else depth <= depth - 8'd1;
         end
         wbuf <= '0; wlen <= '0;
      end else begin
         wbuf <= {wbuf[31:0], bus.chk_in};
         if (wlen != 4'd15) wlen <= wlen + 4'd1;
      end
   end

   assign bus.chk_result = !err && (depth == 8'd0);

   // Response monitor
   always @(negedge clk) begin
      if (bus.resp_valid != 2'b00) begin
         rv_q.push_back(bus.resp_valid);
         res_q.push_back(bus.resp_result);
         ab_q.push_back(bus.resp_abort);
         len_log.push_back(bus.resp_len);
         last_cyc = cyc;
      end
      if (bus.chk_rst) rst_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input int idx, input logic [7:0] c);
      int n;
      bit done;
      @(negedge clk);
      if (idx == 0) begin v0 = 1'b1; c0 = c; end
      else          begin v1 = 1'b1; c1 = c; end
      n = 0;
      done = 0;
      while (!done && n < 400) begin
         #1;
         if (bus.req_ready[idx]) begin
            @(posedge clk);
            #1;
            if (idx == 0 && c == 8'h0A) term_cyc0 = cyc;
            done = 1;
         end else begin
            @(negedge clk);
            n++;
         end
      end
      if (!done) check("push_ready", {31'b0, bus.req_ready[idx]}, 32'd1);
   endtask

   task automatic send(input int idx, input string s);
      for (int i = 0; i < s.len(); i++) push(idx, s[i]);
      @(negedge clk);
      if (idx == 0) v0 = 1'b0;
      else          v1 = 1'b0;
   endtask

   task automatic wait_resp(input int n, input int budget);
      int k;
      k = 0;
      while (rv_q.size() < n && k < budget) begin
         @(negedge clk);
         #2;
         k++;
      end
      check("resp_count", rv_q.size(), n);
      repeat (3) @(negedge clk);
   endtask

   task automatic expect_resp(input string tag, input int idx, input logic [1:0] rv,
                              input logic res, input logic ab, input logic [15:0] len);
      if (rv_q.size() > idx) begin
         check({tag, "_valid"},  {30'b0, rv_q[idx]},   {30'b0, rv});
         check({tag, "_result"}, {31'b0, res_q[idx]},  {31'b0, res});
         check({tag, "_abort"},  {31'b0, ab_q[idx]},   {31'b0, ab});
         check({tag, "_len"},    {16'b0, len_log[idx]}, {16'b0, len});
      end else begin
         check({tag, "_missing"}, rv_q.size(), idx + 1);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; v0 = 1'b0; v1 = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_chk_in"},  {24'b0, bus.chk_in},      32'h20);
      check({tag, "_chk_rst"}, {31'b0, bus.chk_rst},     32'd0);
      check({tag, "_ready"},   {30'b0, bus.req_ready},   32'd0);
      check({tag, "_rvalid"},  {30'b0, bus.resp_valid},  32'd0);
      check({tag, "_rresult"}, {31'b0, bus.resp_result}, 32'd0);
      check({tag, "_rabort"},  {31'b0, bus.resp_abort},  32'd0);
      check({tag, "_rlen"},    {16'b0, bus.resp_len},    32'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int base;
      int r0;
      reset = 1'b1; v0 = 1'b0; v1 = 1'b0; c0 = 8'h00; c1 = 8'h00;
      repeat (3) @(negedge clk);
      #1;
      check_reset_outputs("rst");
      reset = 1'b0;

      // Requester 0, balanced session
      base = rv_q.size();
      r0 = rst_cnt;
      send(0, "begin end\n");
      wait_resp(base + 1, 20);
      expect_resp("s1", base, 2'b01, 1'b1, 1'b0, 16'd9);
      check("s1_latency", last_cyc - term_cyc0, 2);
      check("s1_rst_pulses", rst_cnt - r0, 1);
      check("s1_held", {31'b0, bus.resp_result}, 32'd1);

      // Requester 1: unbalanced, then balanced proves the clear
      base = rv_q.size();
      send(1, "end begin\n");
      wait_resp(base + 1, 20);
      expect_resp("s2", base, 2'b10, 1'b0, 1'b0, 16'd9);
      send(1, "begin end\n");
      wait_resp(base + 2, 20);
      expect_resp("s3", base + 1, 2'b10, 1'b1, 1'b0, 16'd9);

      // Tie right after reset: requester 0 first, requester 1 held off
      do_reset();
      base = rv_q.size();
      viol = 0;
      fork
         send(0, "begin end\n");
         send(1, "end begin\n");
         begin
            int n;
            n = 0;
            while (rv_q.size() == base && n < 200) begin
               @(negedge clk);
               #1;
               if (bus.req_ready[1]) viol++;
               n++;
            end
         end
      join
      wait_resp(base + 2, 40);
      expect_resp("tie0", base, 2'b01, 1'b1, 1'b0, 16'd9);
      expect_resp("tie1", base + 1, 2'b10, 1'b0, 1'b0, 16'd9);
      check("tie_ready1_held", viol, 0);

      // Empty session, then a tie goes to requester 1
      base = rv_q.size();
      send(0, "\n");
      wait_resp(base + 1, 20);
      expect_resp("empty", base, 2'b01, 1'b1, 1'b0, 16'd0);
      fork
         send(0, "begin end\n");
         send(1, "begin\n");
      join
      wait_resp(base + 3, 40);
      expect_resp("tie2a", base + 1, 2'b10, 1'b0, 1'b0, 16'd5);
      expect_resp("tie2b", base + 2, 2'b01, 1'b1, 1'b0, 16'd9);

      // Reset mid-session after "begi"
      base = rv_q.size();
      send(0, "begi");
      reset = 1'b1;
      #1;
      check_reset_outputs("midrst");
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      #2;
      check("midrst_no_resp", rv_q.size(), base);
      send(0, "begin end\n");
      wait_resp(base + 1, 20);
      expect_resp("after_rst", base, 2'b01, 1'b1, 1'b0, 16'd9);

      // Idle streaming: timeout abort, or indefinite wait without the feature
      base = rv_q.size();
      send(0, "begin");
`ifdef ARB_TIMEOUT_EN
      wait_resp(base + 1, 30);
      expect_resp("tmo", base, 2'b01, 1'b0, 1'b1, 16'd5);
`else
      repeat (300) @(negedge clk);
      #2;
      check("no_tmo_resp", rv_q.size(), base);
      send(0, "\n");
      wait_resp(base + 1, 20);
      expect_resp("late_term", base, 2'b01, 1'b0, 1'b0, 16'd5);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule

// File: doc/word_check_arbiter.md
# word_check_arbiter

Shares one begin/end word checker between two character-stream requesters, one whole session at a time. A granted requester streams characters until it sends the terminator. The block then flushes the checker, captures its verdict, returns the verdict to that requester and resets the checker. It sits between the two text sources and the single checker instance, and is the only driver of the checker's input and reset.

## Interface
- TERM, 8'h0A, session terminator character; it is never forwarded to the checker.
- FILL, 8'h20, filler character driven on chk_in when no character is being forwarded. Space is neutral to the checker.
- TIMEOUT, 255, idle-cycle limit used only when ARB_TIMEOUT_EN is defined.
- clk  in  1  clock; all registers update on the rising edge.
- reset  in  1  reset, asynchronous, active-high.
- req_valid  in  2  per-requester character valid; bit i belongs to requester i.
- req_char  in  16  requester i drives its character on bits [8i+7:8i].
- req_ready  out  2  per-requester accept; a character is taken when valid and ready are both high at a clock edge.
- chk_in  out  8  registered character to the checker, which consumes it every cycle.
- chk_rst  out  1  registered one-cycle reset pulse to the checker.
- chk_result  in  1  checker verdict; 1 means balanced.
- resp_valid  out  2  one-cycle pulse to the requester whose session completed.
- resp_result  out  1  captured verdict; held until the next response.
- resp_abort  out  1  1 if the session was aborted by timeout; held with resp_result.
- resp_len  out  16  number of characters forwarded in the session, terminator excluded; saturates at 16'hFFFF.

## Operation
- States: IDLE, STREAM, FLUSH, SAMPLE, CLEAR.
- **IDLE**
  - req_ready = 0 and chk_in = FILL.
  - If any req_valid bit is high: grant that requester, clear len, go to STREAM.
  - If both are high: grant the requester that was not served last. The last pointer resets to 1, so requester 0 wins the first tie.
- **STREAM**
  - req_ready[g] = req_valid[g] for the granted requester g; the other requester's ready stays 0.
  - On acceptance of a character c != TERM: chk_in <= c, len += 1 (saturating).
  - On acceptance of TERM: chk_in <= FILL, go to FLUSH.
  - With no acceptance: chk_in <= FILL.
- **FLUSH**: one cycle; the checker consumes the flush space. Go to SAMPLE.
- **SAMPLE**
  - resp_result <= chk_result, resp_len <= len, resp_abort <= 0.
  - Pulse resp_valid[g], pulse chk_rst, set last <= g, go to CLEAR.
- **CLEAR**: chk_rst returns low and the state goes to IDLE. A new grant is possible from IDLE on the next edge.
- An empty session (TERM as the first character) is legal. It yields resp_len = 0 and resp_result = chk_result, which is 1 for a freshly cleared checker.
- A non-granted requester is never stalled by protocol rules; it simply sees req_ready = 0 until it is granted.

## Timing
- Reset values: state IDLE, chk_in = FILL, chk_rst = 0, req_ready = 0, resp_valid = 0, resp_result = 0, resp_abort = 0, resp_len = 0, last = 1.
- A reset mid-session aborts silently: no resp_valid is issued. The checker must also be reset by the system reset.
- req_valid rising in IDLE at edge E0 grants at E0; req_ready can be high from E0 to E1.
- A character accepted at edge E appears on chk_in after E and is consumed by the checker at E+1.
- TERM accepted at E0:
  - E1: FLUSH space consumed by the checker.
  - E2: SAMPLE; resp_valid and chk_rst are high from E2 to E3.
  - E3: back in IDLE.
  - TERM-to-resp_valid latency is 2 cycles.
- Session turnaround: at least 4 cycles from TERM acceptance to the first character of the next session.

## Configuration
- **ARB_TIMEOUT_EN defined**
  - An 8-bit idle counter counts consecutive STREAM cycles with no acceptance; it is cleared on every acceptance.
  - When it reaches TIMEOUT: go to FLUSH, and SAMPLE reports resp_abort = 1. resp_result is still captured and resp_len is reported.
- **ARB_TIMEOUT_EN undefined**: no counter; resp_abort is tied to 0; STREAM waits indefinitely.

## Test plan
- Requester 0 sends "begin end\n" -> resp_valid = 2'b01 two cycles after TERM, resp_result = 1, resp_len = 9, one chk_rst pulse.
- Requester 1 sends "end begin\n" -> resp_valid = 2'b10, resp_result = 0, resp_len = 9. The next session, "begin end\n" on requester 1, gives resp_result = 1, proving the clear.
- Both requesters raise valid in the same cycle after reset -> requester 0 is served first and requester 1 immediately after. req_ready[1] stays 0 throughout requester 0's session.
- Requester 0 sends "\n" only -> resp_result = 1, resp_len = 0. Then requester 0 and requester 1 both request -> requester 1 wins.
- reset asserted mid-session after "begi" -> all outputs return to reset values at once and no resp_valid is issued. A fresh "begin end\n" then passes with resp_result = 1.
- With ARB_TIMEOUT_EN and TIMEOUT = 4: requester 0 sends "begin" then holds valid low -> resp_abort = 1, resp_result = 0, resp_len = 5. Without the macro, no response ever arrives.
